// File: rtl/enemy_projectile.sv
//-----------------------------------------------------------------------------
// Module  : enemy_projectile
// Brief   : Pool of falling enemy projectiles with launch handshake, per-frame
//           motion, player hit detection and per-pixel circle drawing.
//           Optional steering toward the player: define ENEMY_PROJ_AIMED_EN.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module enemy_projectile #(
    parameter int         NUM_SLOTS  = 4,
    parameter logic [9:0] PROJ_STEP  = 10'd4,
    parameter logic [9:0] PROJ_SIZE  = 10'd3,
    parameter logic [9:0] Y_MAX      = 10'd479,
    parameter logic [9:0] HIT_HALF_W = 10'd8,
    parameter logic [9:0] HIT_HALF_H = 10'd8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       fire_req,
    input  logic [9:0] fire_x,
    input  logic [9:0] fire_y,
    output logic       fire_ack,
    input  logic [9:0] player_x_pos,
    input  logic [9:0] player_y_pos,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       is_enemy_missile,
    output logic       player_hit,
    output logic [2:0] active_count
);

    localparam logic [0:0]         ST_IDLE   = 1'b0;
    localparam logic [0:0]         ST_FLYING = 1'b1;
    localparam logic signed [31:0] C_SIZE_SQ = $signed(32'(PROJ_SIZE) * 32'(PROJ_SIZE));

    logic                 frame_clk_q;
    logic                 frame_edge_q;
    logic [NUM_SLOTS-1:0] state_q, state_d;
    logic [9:0]           x_q [NUM_SLOTS];
    logic [9:0]           x_d [NUM_SLOTS];
    logic [9:0]           y_q [NUM_SLOTS];
    logic [9:0]           y_d [NUM_SLOTS];
    logic                 fire_ack_q, fire_ack_d;
    logic                 player_hit_q, player_hit_d;
    logic [2:0]           active_count_q, active_count_d;

    logic [10:0]          w_y_next [NUM_SLOTS];
    logic [9:0]           w_x_move [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_off_screen;
    logic [NUM_SLOTS-1:0] w_in_box;
    logic [NUM_SLOTS-1:0] w_draw;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_clk_q    <= 1'b0;
            frame_edge_q   <= 1'b0;
            state_q        <= '0;
            fire_ack_q     <= 1'b0;
            player_hit_q   <= 1'b0;
            active_count_q <= '0;
        end else begin
            frame_clk_q    <= frame_clk;
            frame_edge_q   <= frame_clk & ~frame_clk_q;
            state_q        <= state_d;
            fire_ack_q     <= fire_ack_d;
            player_hit_q   <= player_hit_d;
            active_count_q <= active_count_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
            logic signed [11:0] w_dx;
            logic signed [11:0] w_dy;
            logic [11:0]        w_adx;
            logic [11:0]        w_ady;
            logic signed [31:0] w_dist_x;
            logic signed [31:0] w_dist_y;

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    x_q[i] <= '0;
                    y_q[i] <= '0;
                end else begin
                    x_q[i] <= x_d[i];
                    y_q[i] <= y_d[i];
                end
            end

            // 11-bit sum so a projectile near the bottom cannot wrap to the top
            assign w_y_next[i]     = {1'b0, y_q[i]} + {1'b0, PROJ_STEP};
            assign w_off_screen[i] = (w_y_next[i] > {1'b0, Y_MAX});

`ifdef ENEMY_PROJ_AIMED_EN
            assign w_x_move[i] = (x_q[i] < player_x_pos) ? x_q[i] + 10'd1 :
                                 (x_q[i] > player_x_pos) ? x_q[i] - 10'd1 : x_q[i];
`else
            assign w_x_move[i] = x_q[i];
`endif

            assign w_dx  = $signed({2'b00, w_x_move[i]}) - $signed({2'b00, player_x_pos});
            assign w_dy  = $signed({1'b0, w_y_next[i]}) - $signed({2'b00, player_y_pos});
            assign w_adx = w_dx[11] ? 12'(-w_dx) : 12'(w_dx);
            assign w_ady = w_dy[11] ? 12'(-w_dy) : 12'(w_dy);
            assign w_in_box[i] = (w_adx <= {2'b00, HIT_HALF_W}) &&
                                 (w_ady <= {2'b00, HIT_HALF_H});

            assign w_dist_x  = $signed({22'd0, DrawX}) - $signed({22'd0, x_q[i]});
            assign w_dist_y  = $signed({22'd0, DrawY}) - $signed({22'd0, y_q[i]});
            assign w_draw[i] = (state_q[i] == ST_FLYING) &&
                               ((w_dist_x * w_dist_x + w_dist_y * w_dist_y) <= C_SIZE_SQ);
        end
    endgenerate

    // Next-state: flying slots move on a frame edge, the lowest idle slot
    // takes a launch. A freshly launched slot was idle, so it never moves.
    always_comb begin
        logic launched;
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        fire_ack_d     = 1'b0;
        player_hit_d   = 1'b0;
        active_count_d = '0;
        launched       = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (state_q[i] == ST_FLYING) begin
                if (frame_edge_q) begin
                    if (w_off_screen[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (w_in_box[i]) begin
                        state_d[i]   = ST_IDLE;
                        player_hit_d = 1'b1;
                    end else begin
                        x_d[i] = w_x_move[i];
                        y_d[i] = w_y_next[i][9:0];
                    end
                end
            end else if (fire_req && !fire_ack_q && !launched) begin
                launched   = 1'b1;
                state_d[i] = ST_FLYING;
                x_d[i]     = fire_x;
                y_d[i]     = fire_y;
                fire_ack_d = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            active_count_d = active_count_d + {2'b00, state_d[i]};
        end
    end

    // Outputs
    always_comb begin
        fire_ack         = fire_ack_q;
        player_hit       = player_hit_q;
        active_count     = active_count_q;
        is_enemy_missile = |w_draw;
    end

endmodule

`default_nettype wire
